// File: rtl/maze_solver.sv
// Wall-following maze solver: after each forward move it settles, reads the IR openings
// and issues either another forward move or a heading change to the navigation FSM.
module maze_solver #(
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_md,
    input  logic        cmd0,
    input  logic        mv_cmplt,
    input  logic        sol_cmplt,
    input  logic        lft_opn,
    input  logic        rght_opn,
    input  logic        frwrd_opn,
    output logic        strt_mv,
    output logic        strt_hdng,
    output logic        stp_lft,
    output logic        stp_rght,
    output logic [11:0] dsrd_hdng
);

    // state   | meaning
    // IDLE    | waiting for cmd_md with no solution found
    // MV_WAIT | forward move in progress
    // SETTLE  | IR settle countdown before the decision
    // HD_WAIT | heading change in progress
    // DONE    | exit found, held until cmd_md drops

    localparam logic [11:0] HD_N = 12'h000;
    localparam logic [11:0] HD_W = 12'h3FF;
    localparam logic [11:0] HD_S = 12'h7FF;
    localparam logic [11:0] HD_E = 12'hC00;
    localparam logic [3:0]  SETTLE_LD = 4'(SETTLE_CYC);

    typedef enum logic [2:0] {IDLE, MV_WAIT, SETTLE, HD_WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mv_q, mv_d;
    logic        hd_q, hd_d;
    logic [11:0] hdng_q, hdng_d;
    logic        pref_opn, other_opn;

    function automatic logic [11:0] turn_left(input logic [11:0] h);
        case (h)
            HD_N:    return HD_W;
            HD_W:    return HD_S;
            HD_S:    return HD_E;
            HD_E:    return HD_N;
            default: return h;
        endcase
    endfunction

    function automatic logic [11:0] turn_right(input logic [11:0] h);
        case (h)
            HD_N:    return HD_E;
            HD_E:    return HD_S;
            HD_S:    return HD_W;
            HD_W:    return HD_N;
            default: return h;
        endcase
    endfunction

    function automatic logic [11:0] turn_back(input logic [11:0] h);
        case (h)
            HD_N:    return HD_S;
            HD_S:    return HD_N;
            HD_W:    return HD_E;
            HD_E:    return HD_W;
            default: return h;
        endcase
    endfunction

    // Right affinity mirrors the left-wall rules: preferred side becomes the right one.
    assign pref_opn  = cmd0 ? rght_opn : lft_opn;
    assign other_opn = cmd0 ? lft_opn  : rght_opn;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mv_d    = 1'b0;
        hd_d    = 1'b0;
        hdng_d  = hdng_q;
        if (!cmd_md) begin
            state_d = IDLE;
        end else if (state_q != IDLE && sol_cmplt) begin
            state_d = DONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!sol_cmplt) begin
                        mv_d    = 1'b1;
                        state_d = MV_WAIT;
                    end
                end
                MV_WAIT: begin
                    if (mv_cmplt) begin
                        cnt_d   = SETTLE_LD;
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        if (pref_opn) begin
                            hd_d    = 1'b1;
                            hdng_d  = cmd0 ? turn_right(hdng_q) : turn_left(hdng_q);
                            state_d = HD_WAIT;
                        end else if (frwrd_opn) begin
                            mv_d    = 1'b1;
                            state_d = MV_WAIT;
                        end else if (other_opn) begin
                            hd_d    = 1'b1;
                            hdng_d  = cmd0 ? turn_left(hdng_q) : turn_right(hdng_q);
                            state_d = HD_WAIT;
                        end else begin
                            hd_d    = 1'b1;
                            hdng_d  = turn_back(hdng_q);
                            state_d = HD_WAIT;
                        end
                    end
                end
                HD_WAIT: begin
                    if (mv_cmplt) begin
                        mv_d    = 1'b1;
                        state_d = MV_WAIT;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mv_q    <= 1'b0;
            hd_q    <= 1'b0;
            hdng_q  <= HD_N;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mv_q    <= mv_d;
            hd_q    <= hd_d;
            hdng_q  <= hdng_d;
        end
    end

    assign strt_mv   = mv_q;
    assign strt_hdng = hd_q;
    assign dsrd_hdng = hdng_q;
    assign stp_lft   = cmd_md & ~cmd0;
    assign stp_rght  = cmd_md & cmd0;

endmodule

// File: tb/tb_maze_solver.sv
// Directed bench for maze_solver: decisions, latencies, abort/done paths and reset.
module tb_maze_solver;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst_n, cmd_md, cmd0, mv_cmplt, sol_cmplt;
    logic        lft_opn, rght_opn, frwrd_opn;
    logic        strt_mv, strt_hdng, stp_lft, stp_rght;
    logic [11:0] dsrd_hdng;

    int n_chk = 0;
    int n_err = 0;
    int n_mv = 0;
    int n_hd = 0;
    int n_both = 0;
    int snap_mv, snap_hd;

    maze_solver #(.SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_md(cmd_md), .cmd0(cmd0),
        .mv_cmplt(mv_cmplt), .sol_cmplt(sol_cmplt),
        .lft_opn(lft_opn), .rght_opn(rght_opn), .frwrd_opn(frwrd_opn),
        .strt_mv(strt_mv), .strt_hdng(strt_hdng),
        .stp_lft(stp_lft), .stp_rght(stp_rght), .dsrd_hdng(dsrd_hdng)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (strt_mv === 1'b1) n_mv++;
        if (strt_hdng === 1'b1) n_hd++;
        if (strt_mv === 1'b1 && strt_hdng === 1'b1) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_mv();
        mv_cmplt = 1'b1;
        tick();
        mv_cmplt = 1'b0;
    endtask

    // mv_cmplt from MV_WAIT, then expect the decision pulse SETTLE+1 edges later.
    task automatic settle_decide(input string tag, input bit exp_hd, input logic [11:0] exp_hdng);
        pulse_mv();
        for (int i = 0; i < SETTLE; i++) begin
            chk({tag, "_quiet_mv"}, 32'(strt_mv), 32'd0);
            chk({tag, "_quiet_hd"}, 32'(strt_hdng), 32'd0);
            tick();
        end
        chk({tag, "_strt_hdng"}, 32'(strt_hdng), 32'(exp_hd));
        chk({tag, "_strt_mv"}, 32'(strt_mv), 32'(!exp_hd));
        chk({tag, "_dsrd_hdng"}, 32'(dsrd_hdng), 32'(exp_hdng));
        tick();
        chk({tag, "_pulse_end"}, 32'(strt_mv | strt_hdng), 32'd0);
    endtask

    task automatic hd_done(input string tag);
        pulse_mv();
        chk({tag, "_hd_mv"}, 32'(strt_mv), 32'd1);
        chk({tag, "_hd_nohd"}, 32'(strt_hdng), 32'd0);
        tick();
        chk({tag, "_hd_mv_end"}, 32'(strt_mv), 32'd0);
    endtask

    task automatic snap();
        snap_mv = n_mv;
        snap_hd = n_hd;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_no_mv"}, 32'(n_mv), 32'(snap_mv));
        chk({tag, "_no_hd"}, 32'(n_hd), 32'(snap_hd));
    endtask

    initial begin
        rst_n = 1'b0; cmd_md = 1'b0; cmd0 = 1'b0; mv_cmplt = 1'b0; sol_cmplt = 1'b0;
        lft_opn = 1'b0; rght_opn = 1'b0; frwrd_opn = 1'b0;
        #12;
        chk("rst_strt_mv", 32'(strt_mv), 32'd0);
        chk("rst_strt_hdng", 32'(strt_hdng), 32'd0);
        chk("rst_hdng", 32'(dsrd_hdng), 32'h000);
        chk("rst_stp_lft", 32'(stp_lft), 32'd0);

        // 1: start from IDLE
        tick();
        rst_n = 1'b1; cmd_md = 1'b1; cmd0 = 1'b0;
        #1;
        chk("t1_stp_lft", 32'(stp_lft), 32'd1);
        chk("t1_stp_rght", 32'(stp_rght), 32'd0);
        tick();
        chk("t1_strt_mv", 32'(strt_mv), 32'd1);
        chk("t1_hdng", 32'(dsrd_hdng), 32'h000);
        tick();
        chk("t1_strt_mv_end", 32'(strt_mv), 32'd0);

        // 2: left affinity from N with left open
        lft_opn = 1'b1; frwrd_opn = 1'b1; rght_opn = 1'b1;
        settle_decide("t2_left", 1'b1, 12'h3FF);
        hd_done("t2");

        // 3: heading W, forward only, then dead end
        lft_opn = 1'b0; frwrd_opn = 1'b1; rght_opn = 1'b1;
        settle_decide("t3_fwd", 1'b0, 12'h3FF);
        lft_opn = 1'b0; frwrd_opn = 1'b0; rght_opn = 1'b0;
        settle_decide("t3_180", 1'b1, 12'hC00);
        hd_done("t3");

        // 4: right affinity from N
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; cmd0 = 1'b1;
        tick();
        chk("t4_strt_mv", 32'(strt_mv), 32'd1);
        chk("t4_stp_rght", 32'(stp_rght), 32'd1);
        chk("t4_stp_lft", 32'(stp_lft), 32'd0);
        tick();
        lft_opn = 1'b0; frwrd_opn = 1'b1; rght_opn = 1'b1;
        settle_decide("t4_right", 1'b1, 12'hC00);
        hd_done("t4a");
        lft_opn = 1'b1; frwrd_opn = 1'b0; rght_opn = 1'b0;
        settle_decide("t4_leftE", 1'b1, 12'h000);
        hd_done("t4b");
        settle_decide("t4_leftN", 1'b1, 12'h3FF);
        hd_done("t4c");

        // 5: sol_cmplt beats mv_cmplt in MV_WAIT
        snap();
        sol_cmplt = 1'b1; mv_cmplt = 1'b1;
        tick();
        sol_cmplt = 1'b0; mv_cmplt = 1'b0;
        for (int i = 0; i < SETTLE + 3; i++) tick();
        pulse_mv();
        tick(); tick();
        chk_quiet("t5_done");
        cmd_md = 1'b0;
        tick();
        cmd_md = 1'b1;
        tick();
        chk("t5_restart", 32'(strt_mv), 32'd1);
        chk("t5_hdng_kept", 32'(dsrd_hdng), 32'h3FF);

        // 6: abort in SETTLE, stray mv_cmplt in IDLE
        cmd0 = 1'b0; lft_opn = 1'b1; frwrd_opn = 1'b0; rght_opn = 1'b0;
        tick();
        pulse_mv();
        tick();
        snap();
        cmd_md = 1'b0;
        tick();
        pulse_mv();
        for (int i = 0; i < SETTLE + 2; i++) tick();
        chk_quiet("t6_settle_abort");
        cmd_md = 1'b1;
        tick();
        chk("t6_restart1", 32'(strt_mv), 32'd1);
        tick();
        settle_decide("t6_leftW", 1'b1, 12'h7FF);
        snap();
        cmd_md = 1'b0;
        tick();
        pulse_mv();
        for (int i = 0; i < 4; i++) tick();
        chk_quiet("t6_hd_abort");
        cmd_md = 1'b1;
        tick();
        chk("t6_restart2", 32'(strt_mv), 32'd1);
        tick();
        settle_decide("t6_leftS", 1'b1, 12'hC00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_rst_hdng", 32'(dsrd_hdng), 32'h000);
        chk("t6_async_rst_mv", 32'(strt_mv), 32'd0);
        tick();
        rst_n = 1'b1;

        // sol_cmplt held in IDLE blocks the start
        sol_cmplt = 1'b1;
        snap();
        for (int i = 0; i < 5; i++) tick();
        chk_quiet("t7_idle_sol");
        sol_cmplt = 1'b0;
        tick();
        chk("t7_start", 32'(strt_mv), 32'd1);
        tick();

        chk("never_both", 32'(n_both), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
